// File: rtl/mic_pkg.sv
// Shared constants and state encoding for the Pmod MIC3 (ADCS7476) reader.
package mic_pkg;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_LEAD_ZEROS = 4;
  localparam int unsigned ADC_DATA_BITS  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } mic_state_e;

endpackage

// File: rtl/sclk_gen.sv
// SPI serial clock divider: idles high while disabled, toggles every SCLK_HALF cycles when enabled,
// and flags the cycle in which each toggle is decided.
module sclk_gen #(
  parameter int unsigned SCLK_HALF = 5
) (
  input  logic Clk_100mhz,
  input  logic Rst_n,
  input  logic en,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int unsigned DivW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            sclk_q, sclk_d;
  logic            half_done;

  always_comb begin
    half_done = en && (div_cnt_q == DivW'(SCLK_HALF - 1));
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    if (!en) begin
      div_cnt_d = '0;
      sclk_d    = 1'b1;
    end else if (half_done) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk_100mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  // Strobes lead the visible sclk edge by one cycle, so data is taken just before sclk rises.
  assign sclk_rise = half_done && !sclk_q;
  assign sclk_fall = half_done && sclk_q;
  assign sclk      = sclk_q;

endmodule

// File: rtl/mic_adc_reader.sv
// SPI master for the ADCS7476 on the Pmod MIC3: one 16-bit frame per sample period, yielding a
// 12-bit sample with a valid pulse, or a frame_err pulse when the leading zeros are missing.
module mic_adc_reader
  import mic_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 5000,
  parameter int unsigned SCLK_HALF     = 5
) (
  input  logic                     Clk_100mhz,
  input  logic                     Rst_n,
  input  logic                     sdata,
  output logic                     cs_n,
  output logic                     sclk,
  output logic [ADC_DATA_BITS-1:0] mic_in,
  output logic                     sample_valid,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int unsigned TimerW = $clog2(SAMPLE_PERIOD);

  mic_state_e                state_q, state_d;
  logic [TimerW-1:0]         timer_q, timer_d;
  logic [ADC_FRAME_BITS-1:0] shift_q, shift_d;
  logic [4:0]                bit_cnt_q, bit_cnt_d;
  logic [ADC_DATA_BITS-1:0]  mic_q, mic_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;
  logic                      overrun_q, overrun_d;
  logic                      cs_n_q, cs_n_d;
  logic                      tick;
  logic                      sclk_en;
  logic                      sclk_rise;
  logic                      sclk_fall;

  sclk_gen #(
    .SCLK_HALF(SCLK_HALF)
  ) u_sclk_gen (
    .Clk_100mhz(Clk_100mhz),
    .Rst_n     (Rst_n),
    .en        (sclk_en),
    .sclk      (sclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  always_comb begin
    tick    = (timer_q == TimerW'(SAMPLE_PERIOD - 1));
    timer_d = tick ? '0 : timer_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    mic_d     = mic_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    overrun_d = overrun_q;
    sclk_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        sclk_en = 1'b1;
        if (tick) overrun_d = 1'b1;
        if (sclk_rise) begin
          shift_d   = {shift_q[ADC_FRAME_BITS-2:0], sdata};
          bit_cnt_d = bit_cnt_q + 1'b1;
          // Result is registered on the last rise so it appears together with DONE.
          if (bit_cnt_q == 5'(ADC_FRAME_BITS - 1)) begin
            state_d = DONE;
            if (shift_d[ADC_FRAME_BITS-1 -: ADC_LEAD_ZEROS] == '0) begin
              mic_d   = shift_d[ADC_DATA_BITS-1:0];
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (tick) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cs_n_d = (state_d != SHIFT);
  end

  always_ff @(posedge Clk_100mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      mic_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      mic_q     <= mic_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign cs_n         = cs_n_q;
  assign mic_in       = mic_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign overrun      = overrun_q;

  assert property (@(posedge Clk_100mhz) disable iff (!Rst_n) !(sclk_rise && sclk_fall));
  assert property (@(posedge Clk_100mhz) disable iff (!Rst_n) !(valid_q && err_q));

endmodule

// File: tb/tb_mic_adc_reader.sv
// Bench for mic_adc_reader: default instance plus a short-period instance forced into overrun.
module tb_mic_adc_reader;

  localparam int PA = 5000;
  localparam int PB = 100;
  localparam int H  = 5;
  localparam int FL = 32 * H;

  logic        clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        sdata_a, sdata_b;
  logic        cs_n_a, cs_n_b, sclk_a, sclk_b;
  logic [11:0] mic_a, mic_b;
  logic        valid_a, valid_b, err_a, err_b, ovr_a, ovr_b;

  always #5 clk = ~clk;

  mic_adc_reader #(.SAMPLE_PERIOD(PA), .SCLK_HALF(H)) dut_a (
    .Clk_100mhz(clk), .Rst_n(Rst_n), .sdata(sdata_a), .cs_n(cs_n_a), .sclk(sclk_a),
    .mic_in(mic_a), .sample_valid(valid_a), .frame_err(err_a), .overrun(ovr_a)
  );

  mic_adc_reader #(.SAMPLE_PERIOD(PB), .SCLK_HALF(H)) dut_b (
    .Clk_100mhz(clk), .Rst_n(Rst_n), .sdata(sdata_b), .cs_n(cs_n_b), .sclk(sclk_b),
    .mic_in(mic_b), .sample_valid(valid_b), .frame_err(err_b), .overrun(ovr_b)
  );

  logic [15:0] words_a [8] = '{16'h0ABC, 16'h0000, 16'h0FFF, 16'h0000,
                               16'h0FFF, 16'h8123, 16'h0555, 16'h0777};
  logic [15:0] words_b [8] = '{16'h0111, 16'h0222, 16'hF333, 16'h0444,
                               16'h0555, 16'h0666, 16'h0777, 16'h0888};

  function automatic logic [15:0] word_for(input int d, input int n);
    if (n >= 8) return 16'h0FA5;
    return (d == 0) ? words_a[n] : words_b[n];
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ADC model: MSB presented when cs_n falls, next bit after every sclk rise.
  logic [15:0] adc_word_a = '0, adc_word_b = '0;
  int          adc_bit_a = 15, adc_bit_b = 15;
  int          adc_n_a = 0, adc_n_b = 0;

  always @(negedge cs_n_a) begin
    adc_word_a = word_for(0, adc_n_a);
    adc_n_a++;
    adc_bit_a = 15;
  end
  always @(posedge sclk_a) if (!cs_n_a && adc_bit_a > 0) adc_bit_a--;
  always @(negedge cs_n_b) begin
    adc_word_b = word_for(1, adc_n_b);
    adc_n_b++;
    adc_bit_b = 15;
  end
  always @(posedge sclk_b) if (!cs_n_b && adc_bit_b > 0) adc_bit_b--;
  assign sdata_a = adc_word_a[adc_bit_a];
  assign sdata_b = adc_word_b[adc_bit_b];

  // Cycles elapsed since reset release.
  int cyc;
  always @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Timeline model: frames begin at free ticks (cyc % P == P-1); outputs derive from the offset.
  int          ft [2] = '{-1000000, -1000000};
  bit          ovr_m [2] = '{1'b0, 1'b0};
  logic [11:0] mic_m [2] = '{12'h0, 12'h0};
  logic [15:0] wcur [2] = '{16'h0, 16'h0};
  int          midx [2] = '{0, 0};
  int          k, p;
  bit          e_cs, e_sclk, e_v, e_e;
  logic        o_cs, o_sclk, o_v, o_e, o_o;
  logic [11:0] o_mic;
  string       pfx;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pfx   = (d == 0) ? "a." : "b.";
      p     = (d == 0) ? PA : PB;
      o_cs  = (d == 0) ? cs_n_a : cs_n_b;
      o_sclk = (d == 0) ? sclk_a : sclk_b;
      o_v   = (d == 0) ? valid_a : valid_b;
      o_e   = (d == 0) ? err_a : err_b;
      o_o   = (d == 0) ? ovr_a : ovr_b;
      o_mic = (d == 0) ? mic_a : mic_b;
      if (!Rst_n) begin
        ft[d]    = -1000000;
        ovr_m[d] = 1'b0;
        mic_m[d] = '0;
        k = -1;
      end else begin
        k = cyc - ft[d];
      end
      e_cs   = !(k >= 1 && k <= FL);
      e_sclk = (k >= 1 && k <= FL) ? (((k - 1) / H) % 2 == 0) : 1'b1;
      e_v    = 1'b0;
      e_e    = 1'b0;
      if (k == FL + 1) begin
        if (wcur[d][15:12] == 4'h0) begin
          e_v      = 1'b1;
          mic_m[d] = wcur[d][11:0];
        end else begin
          e_e = 1'b1;
        end
      end
      chk({pfx, "cs_n"}, 32'(o_cs), 32'(e_cs));
      chk({pfx, "sclk"}, 32'(o_sclk), 32'(e_sclk));
      chk({pfx, "sample_valid"}, 32'(o_v), 32'(e_v));
      chk({pfx, "frame_err"}, 32'(o_e), 32'(e_e));
      chk({pfx, "mic_in"}, 32'(o_mic), 32'(mic_m[d]));
      chk({pfx, "overrun"}, 32'(o_o), 32'(ovr_m[d]));
      if (Rst_n && (cyc % p == p - 1)) begin
        if (k >= 1 && k <= FL + 1) begin
          ovr_m[d] = 1'b1;
        end else begin
          ft[d]   = cyc;
          wcur[d] = word_for(d, midx[d]);
          midx[d]++;
        end
      end
    end
  end

  // Edge statistics for dut_a used by the literal checks.
  logic        pcs = 1'b1, psclk = 1'b1;
  int          frame_no, rises_cur, rises_f1, cs_fall_cyc, last_fall, first_fall_off, fall_gap;
  int          n_valid, n_err, vcyc0, vcyc1;
  logic [11:0] vmic0;

  always @(negedge clk) begin
    if (!Rst_n) begin
      pcs = 1'b1; psclk = 1'b1; frame_no = 0; rises_cur = 0; rises_f1 = 0;
      cs_fall_cyc = 0; last_fall = -1; first_fall_off = -1; fall_gap = -1;
      n_valid = 0; n_err = 0; vcyc0 = -1; vcyc1 = -1; vmic0 = '0;
    end else begin
      if (pcs && !cs_n_a) begin
        frame_no++; rises_cur = 0; cs_fall_cyc = cyc; last_fall = -1;
      end
      if (!psclk && sclk_a && !pcs) begin
        rises_cur++;
        if (frame_no == 1) rises_f1 = rises_cur;
      end
      if (psclk && !sclk_a) begin
        if (frame_no == 1 && last_fall < 0) first_fall_off = cyc - cs_fall_cyc;
        else if (frame_no == 1 && fall_gap < 0) fall_gap = cyc - last_fall;
        last_fall = cyc;
      end
      if (valid_a) begin
        n_valid++;
        if (n_valid == 1) begin vcyc0 = cyc; vmic0 = mic_a; end
        if (n_valid == 2) vcyc1 = cyc;
      end
      if (err_a) n_err++;
      pcs = cs_n_a; psclk = sclk_a;
    end
  end

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    chk("wait_cyc", 32'(cyc), 32'(target));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".a.cs_n"}, 32'(cs_n_a), 32'd1);
    chk({tag, ".a.sclk"}, 32'(sclk_a), 32'd1);
    chk({tag, ".a.mic_in"}, 32'(mic_a), 32'd0);
    chk({tag, ".a.valid"}, 32'(valid_a), 32'd0);
    chk({tag, ".a.err"}, 32'(err_a), 32'd0);
    chk({tag, ".b.cs_n"}, 32'(cs_n_b), 32'd1);
    chk({tag, ".b.sclk"}, 32'(sclk_b), 32'd1);
    chk({tag, ".b.mic_in"}, 32'(mic_b), 32'd0);
    chk({tag, ".b.overrun"}, 32'(ovr_b), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    Rst_n = 1'b1;

    // Short-period instance: first frame at tick 99, tick 199 collides.
    wait_cyc(199);
    chk("b.overrun_before", 32'(ovr_b), 32'd0);
    wait_cyc(200);
    chk("b.overrun_set", 32'(ovr_b), 32'd1);

    // First frame of dut_a: tick 4999, valid 161 cycles later.
    wait_cyc(5161);
    chk("a.first_valid_cyc", 32'(vcyc0), 32'd5160);
    chk("a.first_mic", 32'(vmic0), 32'h0ABC);
    chk("a.rises_frame1", 32'(rises_f1), 32'd16);
    chk("a.first_fall_off", 32'(first_fall_off), 32'd5);
    chk("a.sclk_period", 32'(fall_gap), 32'd10);

    // Alternating samples then one rejected frame.
    wait_cyc(30200);
    chk("a.valid_count", 32'(n_valid), 32'd5);
    chk("a.err_count", 32'(n_err), 32'd1);
    chk("a.valid_spacing", 32'(vcyc1 - vcyc0), 32'd5000);
    chk("a.mic_held_after_err", 32'(mic_a), 32'h0FFF);
    chk("b.overrun_sticky", 32'(ovr_b), 32'd1);

    // Seventh frame (tick 34999): 8th sclk rise is visible at cycle 35080.
    wait_cyc(35080);
    chk("a.rises_before_rst", 32'(rises_cur), 32'd8);
    chk("a.cs_low_before_rst", 32'(cs_n_a), 32'd0);
    Rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (3) @(negedge clk);
    Rst_n = 1'b1;

    wait_cyc(5161);
    chk("a.post_rst_valid_count", 32'(n_valid), 32'd1);
    chk("a.post_rst_valid_cyc", 32'(vcyc0), 32'd5160);
    chk("a.post_rst_mic", 32'(mic_a), 32'h0777);
    chk("a.post_rst_err_count", 32'(n_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mic_adc_reader.md
Name: mic_adc_reader

Overview:
SPI master for the Pmod MIC3 (ADCS7476, 12-bit serial ADC) on the Basys3. It produces the 12-bit microphone sample stream that the peak/volume logic consumes. It runs on the 100 MHz system clock and starts one conversion every SAMPLE_PERIOD cycles (20 kHz by default). Each completed sample is presented on mic_in, held stable, and flagged with a single-cycle sample_valid pulse.

Parameters:
SAMPLE_PERIOD, 5000, system-clock cycles between conversion starts (100 MHz / 5000 = 20 kHz); legal range is at least 32*SCLK_HALF+2.
SCLK_HALF, 5, system-clock cycles per SCLK half-period (5 gives 10 MHz SCLK); minimum 3, since the ADC limit is 20 MHz.

Ports:
Clk_100mhz  input   1   system clock, all logic on its rising edge
Rst_n       input   1   reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
sdata       input   1   ADC serial data, MSB first
cs_n        output  1   ADC chip select, active-low
sclk        output  1   ADC serial clock, idles high
mic_in      output  12  last good sample, held until the next good sample
sample_valid output 1   one-cycle pulse when mic_in updates
frame_err   output  1   one-cycle pulse when a frame is rejected
overrun     output  1   sticky; set when a sample tick arrives while a frame is still active; cleared only by reset

Behaviour:
- Reset (Rst_n=0, asynchronous): cs_n=1, sclk=1, mic_in=0, sample_valid=0, frame_err=0, overrun=0. Timer, shift register, bit counter and divider counter all = 0; state = IDLE.
- Reset mid-frame: the same values apply immediately. There is no partial update of mic_in.
- Sample timer: free-running, counts 0..SAMPLE_PERIOD-1 and wraps. tick=1 in the cycle where the count equals SAMPLE_PERIOD-1.
- States are IDLE, SHIFT and DONE.
- IDLE to SHIFT:
  - Transition happens on tick; call the tick cycle T.
  - At T+1: cs_n=0, sclk=1, div_cnt=0, bit_cnt=0.
- SHIFT, SCLK generation:
  - div_cnt counts 0..SCLK_HALF-1.
  - At div_cnt=SCLK_HALF-1, sclk toggles and div_cnt returns to 0.
  - The first toggle is high-to-low, SCLK_HALF cycles after cs_n falls.
- SHIFT, data capture:
  - On each low-to-high sclk toggle, sdata is shifted into a 16-bit register (LSB in) and bit_cnt increments.
  - sdata is sampled directly with no synchronizer; it is source-synchronous to the block's own sclk.
- SHIFT to DONE: on the 16th rising toggle, after exactly 32*SCLK_HALF cycles in SHIFT (T+32*SCLK_HALF).
- DONE, one cycle at T+32*SCLK_HALF+1:
  - cs_n=1 and sclk=1.
  - If shift[15:12]==0: mic_in <= shift[11:0] and sample_valid=1.
  - Otherwise: mic_in is unchanged, frame_err=1 and sample_valid=0.
  - Next state is IDLE.
- Latency from tick to sample_valid is 32*SCLK_HALF+1 cycles (161 cycles at default).
- A tick occurring in SHIFT or DONE is ignored, no frame starts, and overrun is set. A tick in the same cycle as DONE counts as busy.
- sample_valid and frame_err are never high together.
- cs_n stays high in IDLE and DONE. sclk changes only while cs_n=0.
- Width rules: the timer is $clog2(SAMPLE_PERIOD) bits, bit_cnt is 5 bits and div_cnt is $clog2(SCLK_HALF) bits. No arithmetic is done on sample data.

Decomposition:
- Shared package (mic_pkg) holds:
  - ADC_FRAME_BITS=16, ADC_LEAD_ZEROS=4, ADC_DATA_BITS=12;
  - the state encoding (IDLE/SHIFT/DONE, 2 bits).
- One sub-module, sclk_gen. It takes an enable and SCLK_HALF and outputs sclk plus rise/fall strobes. The FSM, timer and shift register stay in mic_adc_reader.

Test Plan:
1. ADC model returns 0x0ABC (4 zeros followed by 0xABC) -> mic_in=0xABC, one sample_valid pulse 161 cycles after tick, and exactly 16 rising sclk edges while cs_n=0.
2. Free run for 1 ms with alternating samples 0x0000 and 0x0FFF -> exactly 20 sample_valid pulses spaced 5000 cycles apart, with mic_in alternating 0x000/0xFFF and held between pulses.
3. Model drives leading bits 1000 with data 0x123 -> frame_err pulses, sample_valid stays 0, and mic_in keeps its previous value.
4. Rst_n dropped at the 8th sclk rise -> cs_n=1, sclk=1 and all outputs 0 in the same cycle (async). After release, the next frame starts at the first tick (SAMPLE_PERIOD-1 cycles later) and completes normally.
5. Override SAMPLE_PERIOD=100 with SCLK_HALF=5 (frame longer than period) -> overrun goes high at the first colliding tick and stays high. Frames still complete with correct data; no frame starts mid-frame.
6. Check sclk period over a frame -> 2*SCLK_HALF cycles (100 ns) with 50% duty, first falling edge SCLK_HALF cycles after cs_n falls, and sclk high whenever cs_n=1.
